// File: rtl/sixteen_bit_down_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic reload and sticky irq.
// Define TIMER_CAPTURE_EN to add the capture input and capture_out register.
module sixteen_bit_down_timer #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic                      mode,
  input  logic                      irq_ack,
  output logic [WIDTH-1:0]          count_out,
  output logic                      irq,
  output logic                      irq_ovf,
  output logic                      running,
  output logic                      zero
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic                      capture,
  output logic [WIDTH-1:0]          capture_out
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic [WIDTH-1:0]          reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic                      mode_q, mode_d;
  logic                      irq_q, irq_d;
  logic                      irq_ovf_q, irq_ovf_d;
  logic                      count_en, tick, expire;

  // Load overrides counting, so an expiry coinciding with load is dropped.
  assign count_en = (state_q == RUN) && enable && !load;
  assign tick     = count_en && (presc_cnt_q == '0);
  assign expire   = tick && (count_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = RUN;
        RUN:     if (!enable) state_d = IDLE;
                 else if (expire && !mode_q) state_d = EXPIRED;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state_q == RUN);
    zero    = (count_q == '0);
  end

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    mode_d      = mode_q;
    if (load) begin
      count_d     = load_in;
      reload_d    = load_in;
      prescale_d  = prescale_in;
      presc_cnt_d = prescale_in;
      mode_d      = mode;
    end else if (count_en) begin
      if (tick) begin
        presc_cnt_d = prescale_q;
        if (count_q != '0) count_d = count_q - WIDTH'(1);
        else if (mode_q)   count_d = reload_q;
      end else begin
        presc_cnt_d = presc_cnt_q - PRESCALE_WIDTH'(1);
      end
    end
  end

  // Set beats ack; an overrun needs irq still pending and not being acked.
  always_comb begin
    irq_d     = irq_ack ? 1'b0 : irq_q;
    irq_ovf_d = irq_ack ? 1'b0 : irq_ovf_q;
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) irq_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      reload_q    <= '0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      mode_q      <= 1'b0;
      irq_q       <= 1'b0;
      irq_ovf_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      mode_q      <= mode_d;
      irq_q       <= irq_d;
      irq_ovf_q   <= irq_ovf_d;
    end
  end

  assign count_out = count_q;
  assign irq       = irq_q;
  assign irq_ovf   = irq_ovf_q;

`ifdef TIMER_CAPTURE_EN
  logic [WIDTH-1:0] capture_q, capture_d;

  // Samples the registered count, so a capture alongside load sees the old value.
  always_comb begin
    capture_d = capture ? count_q : capture_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) capture_q <= '0;
    else        capture_q <= capture_d;
  end

  assign capture_out = capture_q;
`endif

endmodule
